// File: rtl/s_box_inverse.sv
// s_box_inverse: iterative AES inverse S-box, one byte per ready/valid transaction.
// Inverse affine on the input, then x^254 via a square/multiply chain over GF(2^8).
module s_box_inverse #(
    parameter logic [7:0] INV_AFFINE_CONSTANT = 8'h05,
    parameter logic [7:0] REDUCE_POLY         = 8'h1B,
    parameter int         NUM_STEPS           = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       input_valid,
    output logic       input_ready,
    input  logic [7:0] input_data,
    output logic       output_valid,
    input  logic       output_ready,
    output logic [7:0] output_data
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t state, next_state;
    logic [7:0] t, acc, b, t_sq, acc_next;
    logic [2:0] cnt;
    logic armed, accept, last;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, a;
        p = 8'h00;
        a = x;
        for (int i = 0; i < 8; i++) begin
            p = y[i] ? p ^ a : p;
            a = {a[6:0], 1'b0} ^ (a[7] ? REDUCE_POLY : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] s, input int n);
        logic [15:0] d;
        d = {s, s} << n;
        return d[15:8];
    endfunction

    assign b        = rotl(input_data, 1) ^ rotl(input_data, 3) ^ rotl(input_data, 6) ^ INV_AFFINE_CONSTANT;
    assign t_sq     = gf_mul(t, t);
    assign acc_next = gf_mul(acc, t_sq);
    assign accept   = input_valid && input_ready;
    assign last     = cnt == 3'(NUM_STEPS - 1);

    // armed keeps input_ready low while reset is held, without a path from the reset pin
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : next_state;
        armed <= !reset;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? COMPUTE : IDLE;
            COMPUTE: next_state = last ? DONE : COMPUTE;
            DONE:    next_state = output_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        input_ready  = state == IDLE && armed;
        output_valid = state == DONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t           <= 8'h00;
            acc         <= 8'h00;
            cnt         <= 3'd0;
            output_data <= 8'h00;
        end else if (accept) begin
            t   <= b;
            acc <= 8'h01;
            cnt <= 3'd0;
        end else if (state == COMPUTE) begin
            t   <= t_sq;
            acc <= acc_next;
            cnt <= cnt + 3'd1;
            if (last)
                output_data <= acc_next;
        end
    end
endmodule

// File: tb/tb_s_box_inverse.sv
// tb_s_box_inverse: directed vectors, corner sequences and randomized/exhaustive runs
// checked against a forward S-box table built from GF(2^8) arithmetic.
module tb_s_box_inverse;
    logic       clock = 0;
    logic       reset = 1;
    logic       input_valid = 0;
    logic       input_ready;
    logic [7:0] input_data = 0;
    logic       output_valid;
    logic       output_ready = 0;
    logic [7:0] output_data;

    int total = 0;
    int bad = 0;
    logic [7:0] sbox [256];

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [8];

    s_box_inverse dut (
        .clock(clock), .reset(reset),
        .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
        .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_inv(input logic [7:0] x);
        for (int y = 1; y < 256; y++)
            if (m_mul(x, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return 8'(((int'(v) << n) | (int'(v) >> (8 - n))) & 255);
    endfunction

    function automatic logic [7:0] fwd(input logic [7:0] x);
        logic [7:0] v;
        v = m_inv(x);
        return v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] model(input logic [7:0] y);
        for (int i = 0; i < 256; i++)
            if (sbox[i] == y) return 8'(i);
        return 8'h00;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int w;
        w = 0;
        input_valid = 1;
        input_data  = d;
        while (!input_ready && w < 50) begin
            step();
            w++;
        end
        if (!input_ready) check("accept timeout", 0, 1);
        step();
        input_valid = 0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!output_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic recv(input logic [7:0] exp, input int stalls, input string nm);
        int lat;
        wait_valid(lat);
        check({nm, " valid"}, output_valid, 1);
        output_ready = 0;
        for (int k = 0; k < stalls; k++) step();
        check({nm, " data"}, output_data, exp);
        output_ready = 1;
        step();
        output_ready = 0;
        check({nm, " no dup"}, output_valid, 0);
        check({nm, " ready back"}, input_ready, 1);
    endtask

    initial begin
        int lat, seen;
        logic [7:0] x;
        for (int i = 0; i < 256; i++) sbox[i] = fwd(8'(i));
        vecs[0] = '{8'h52, 8'h48};
        vecs[1] = '{8'h63, 8'h00};
        vecs[2] = '{8'h7C, 8'h01};
        vecs[3] = '{8'h16, 8'hFF};
        vecs[4] = '{8'hED, 8'h53};
        vecs[5] = '{8'hCA, 8'h10};
        vecs[6] = '{8'hB7, 8'h20};
        vecs[7] = '{8'h09, 8'h40};

        // reset state
        repeat (3) step();
        check("rst input_ready", input_ready, 0);
        check("rst output_valid", output_valid, 0);
        check("rst output_data", output_data, 8'h00);
        reset = 0;
        step();
        check("post-rst input_ready", input_ready, 1);

        // first transaction with output_ready held high, latency check
        output_ready = 1;
        send(8'h52);
        check("busy input_ready", input_ready, 0);
        wait_valid(lat);
        check("latency", lat, 7);
        check("first data", output_data, 8'h48);
        step();
        check("first handshake valid", output_valid, 0);
        check("first ready back", input_ready, 1);
        output_ready = 0;

        // table-driven directed vectors
        foreach (vecs[i]) begin
            send(vecs[i].din);
            recv(vecs[i].exp, i % 3, $sformatf("vec%0d", i));
        end

        // backpressure: result held, second input ignored
        send(8'h7C);
        wait_valid(lat);
        for (int k = 0; k < 20; k++) begin
            input_valid = (k >= 5 && k < 10);
            input_data  = 8'h16;
            check("bp ready", input_ready, 0);
            step();
            check("bp valid", output_valid, 1);
            check("bp data", output_data, 8'h01);
        end
        input_valid = 0;
        output_ready = 1;
        step();
        output_ready = 0;
        check("bp released", output_valid, 0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            seen += int'(output_valid);
        end
        check("bp second not accepted", seen, 0);

        // reset in the 4th COMPUTE cycle aborts the transaction
        send(8'hED);
        repeat (3) step();
        reset = 1;
        step();
        check("abort valid", output_valid, 0);
        check("abort data", output_data, 8'h00);
        check("abort ready", input_ready, 0);
        reset = 0;
        step();
        check("abort ready after", input_ready, 1);
        seen = 0;
        output_ready = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            seen += int'(output_valid);
        end
        output_ready = 0;
        check("no stale result", seen, 0);

        // randomized bytes against the table model
        for (int n = 0; n < 40; n++) begin
            x = 8'($urandom_range(0, 255));
            send(x);
            recv(model(x), int'($urandom_range(0, 3)), "rand");
        end

        // exhaustive: feed SBOX(x), expect x back in order
        for (int i = 0; i < 256; i++) begin
            send(sbox[i]);
            recv(8'(i), int'($urandom_range(0, 2)), "exh");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
